// File: rtl/mem_arbiter2_pkg.sv
// mem_arbiter2_pkg: shared definitions for the two-master memory arbiter.
//   - FSM state encoding, kept as plain constants so that legacy code
//     matching on the raw values still works.
//   - Default starvation limit for the arbiter.
package mem_arbiter2_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_BUSY    = 2'd1;
  localparam arb_state_t ST_RELEASE = 2'd2;

  localparam int MAX_WAIT_DEFAULT = 8;

endpackage

// File: rtl/mem_arbiter2_if.sv
// mem_arbiter2_if: bundle of all request/response signals around the arbiter.
//   m0_* : master 0 (CPU)  valid/addr/wdata/wstrb in, ready/rdata out
//   m1_* : master 1 (DMA)  same as m0_*
//   s_*  : shared SDRAM controller, valid/addr/wdata/wstrb out, ready/rdata in
//   grant: owner of the current or last transaction (0 = m0, 1 = m1)
// Modports:
//   slave  - the arbiter's view (serves both masters, drives the SDRAM side)
//   master - the surrounding system's view (masters + SDRAM controller)
interface mem_arbiter2_if #(
  parameter int ADDR_W = 32
);
  logic              m0_valid;
  logic              m0_ready;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [3:0]        m0_wstrb;
  logic [31:0]       m0_rdata;

  logic              m1_valid;
  logic              m1_ready;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [3:0]        m1_wstrb;
  logic [31:0]       m1_rdata;

  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [31:0]       s_rdata;

  logic              grant;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata,
    output grant
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata,
    input  grant
  );

endinterface

// File: rtl/mem_arbiter2_rr_pick2.sv
// rr_pick2: purely combinational winner selection for two requesters.
//   m0_valid, m1_valid : current requests
//   last_grant         : owner of the previous transaction
//   starve0, starve1   : requester has reached its wait limit
//   any_valid          : at least one request is present
//   winner             : selected requester (0 = m0, 1 = m1)
module rr_pick2 (
  input  logic m0_valid,
  input  logic m1_valid,
  input  logic last_grant,
  input  logic starve0,
  input  logic starve1,
  output logic any_valid,
  output logic winner
);

  always_comb begin
    any_valid = m0_valid | m1_valid;
    winner    = 1'b0;
    if (m0_valid && m1_valid) begin
      // A starving requester overrides round-robin; if both are starving
      // the override cancels out and round-robin decides.
      if (starve0 && !starve1) begin
        winner = 1'b0;
      end else if (starve1 && !starve0) begin
        winner = 1'b1;
      end else begin
        winner = ~last_grant;
      end
    end else begin
      // Lone requester wins even if it also owned the last transaction.
      winner = m1_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: shares one SDRAM controller port between a CPU (m0) and a
// DMA engine (m1).
//   clk    : system clock, all state on its rising edge
//   reset  : asynchronous, active-high
//   bus    : mem_arbiter2_if.slave, carrying m0_*, m1_*, s_* and grant
// Flow: IDLE picks a winner and latches its request, BUSY presents it to
// the controller until s_ready (completion is forwarded combinationally to
// the owner), RELEASE is a single dead cycle so the owner can drop valid.
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter2_if.slave bus
);

  localparam int              CW       = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0]   WAIT_SAT = CW'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic [3:0]        s_wstrb_q, s_wstrb_d;
  logic              grant_q, grant_d;
  logic [CW-1:0]     wait0_q, wait0_d;
  logic [CW-1:0]     wait1_q, wait1_d;

  logic any_valid;
  logic winner;
  logic starve0;
  logic starve1;
  logic busy;
  logic done;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == WAIT_SAT) ? v : v + CW'(1);
  endfunction

  assign starve0 = (wait0_q == WAIT_SAT);
  assign starve1 = (wait1_q == WAIT_SAT);

  rr_pick2 u_pick (
    .m0_valid   (bus.m0_valid),
    .m1_valid   (bus.m1_valid),
    .last_grant (grant_q),
    .starve0    (starve0),
    .starve1    (starve1),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  always_comb begin
    state_d   = state_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    grant_d   = grant_q;
    // A master that drops valid stops waiting, whatever the FSM is doing.
    wait0_d   = bus.m0_valid ? wait0_q : '0;
    wait1_d   = bus.m1_valid ? wait1_q : '0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          state_d = ST_BUSY;
          if (winner) begin
            s_addr_d  = bus.m1_addr;
            s_wdata_d = bus.m1_wdata;
            s_wstrb_d = bus.m1_wstrb;
            wait1_d   = '0;
            if (bus.m0_valid) wait0_d = sat_inc(wait0_q);
          end else begin
            s_addr_d  = bus.m0_addr;
            s_wdata_d = bus.m0_wdata;
            s_wstrb_d = bus.m0_wstrb;
            wait0_d   = '0;
            if (bus.m1_valid) wait1_d = sat_inc(wait1_q);
          end
        end
      end
      ST_BUSY: begin
        if (bus.s_ready) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      grant_q   <= 1'b0;
      wait0_q   <= '0;
      wait1_q   <= '0;
    end else begin
      state_q   <= state_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      grant_q   <= grant_d;
      wait0_q   <= wait0_d;
      wait1_q   <= wait1_d;
    end
  end

  // s_ready outside BUSY never reaches a master.
  assign busy = (state_q == ST_BUSY);
  assign done = busy && bus.s_ready;

  assign bus.s_valid  = busy;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wstrb  = s_wstrb_q;
  assign bus.grant    = grant_q;

  assign bus.m0_ready = done && !grant_q;
  assign bus.m1_ready = done &&  grant_q;
  assign bus.m0_rdata = bus.m0_ready ? bus.s_rdata : '0;
  assign bus.m1_rdata = bus.m1_ready ? bus.s_rdata : '0;

endmodule

// File: doc/mem_arbiter2.md
MEM_ARBITER2 -- requirements
Module: mem_arbiter2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width for both masters and the slave port.
REQ-002 SHALL have parameter MAX_WAIT, default 8, meaning the number of consecutive lost arbitrations after which a waiting master is forced to win.
REQ-003 SHALL have ports:
  - clk  in  1  single system clock.
  - reset  in  1  asynchronous, active-high reset.
  - m0_valid  in  1  master 0 (CPU) request.
  - m0_ready  out  1  master 0 completion pulse.
  - m0_addr  in  ADDR_W  master 0 address.
  - m0_wdata  in  32  master 0 write data.
  - m0_wstrb  in  4  master 0 byte strobes; 0 means read.
  - m0_rdata  out  32  master 0 read data.
  - m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0_*, for master 1 (DMA).
  - s_valid  out  1  request to the shared SDRAM controller.
  - s_ready  in  1  SDRAM controller completion pulse.
  - s_addr  out  ADDR_W  latched address.
  - s_wdata  out  32  latched write data.
  - s_wstrb  out  4  latched strobes.
  - s_rdata  in  32  SDRAM controller read data.
  - grant  out  1  owner of the current or last transaction (0 = m0, 1 = m1).

Function
REQ-004 SHALL implement a three-state FSM: IDLE, BUSY, RELEASE.
REQ-005 IDLE: if any mX_valid is high, SHALL choose a winner, latch its addr, wdata and wstrb into s_* registers, set grant, and go to BUSY on the next edge.
REQ-006 Winner selection SHALL be round-robin: when both masters request, the master not granted last wins.
REQ-007 SHALL count, per master, consecutive IDLE arbitrations lost while that master's valid is high, saturating at MAX_WAIT.
REQ-008 When a master's wait count equals MAX_WAIT, that master SHALL win regardless of round-robin order; the winner's count SHALL clear at grant.
REQ-009 BUSY: s_valid SHALL be 1; it SHALL be 0 in IDLE and RELEASE.
REQ-010 BUSY: s_addr, s_wdata and s_wstrb SHALL hold their latched values; changes on mX_* inputs SHALL have no effect.
REQ-011 BUSY with s_ready=1: the granted master's mX_ready SHALL be 1 in that same cycle (combinational), mX_rdata SHALL equal s_rdata, and the FSM SHALL go to RELEASE.
REQ-012 RELEASE SHALL last exactly one cycle and then go to IDLE. This lets the master drop valid, so a completed request is not re-arbitrated.
REQ-013 The non-granted master's mX_ready SHALL be 0 in every state.
REQ-014 mX_rdata SHALL be 0 whenever mX_ready is 0.
REQ-015 Minimum latency SHALL be: valid seen in IDLE at cycle n, s_valid at n+1, m_ready in the same cycle as s_ready, next grant at the earliest in the cycle after RELEASE.
REQ-016 A master dropping valid while waiting (not granted) SHALL be ignored, and its wait count SHALL clear.
REQ-017 s_ready asserted in IDLE or RELEASE SHALL be ignored: no mX_ready, no state change.
REQ-018 A single requester SHALL be granted without a round-robin penalty, even when it was also granted last.

Reset
REQ-019 While reset is high, asynchronously: state=IDLE, s_valid=0, s_addr/s_wdata/s_wstrb=0, grant=0 (so m1 wins the first contention), both wait counters=0, m0_ready=m1_ready=0.
REQ-020 Reset asserted during BUSY SHALL abort the transaction: s_valid drops immediately and no mX_ready is produced for it.
REQ-021 After reset deasserts, the first grant SHALL occur no earlier than the first rising clk edge that samples reset low.

Structure
REQ-022 The FSM state encoding (IDLE=0, BUSY=1, RELEASE=2) and the default of MAX_WAIT SHALL live in the shared SoC defines package.
REQ-023 A single sub-module, rr_pick2, SHALL compute the winner from (m0_valid, m1_valid, last grant, starve0, starve1) and SHALL be purely combinational.
REQ-024 The block SHALL contain no memories and no clock gating; all registers SHALL be clocked on the rising edge of clk.

Verification
REQ-025 Single read: m0 read at addr 0x2000_0000, s_ready 3 cycles after s_valid with s_rdata=0xDEADBEEF -> m0_ready is one pulse, m0_rdata=0xDEADBEEF, s_wstrb=0.
REQ-026 Contention after reset: both masters request in the same cycle -> m1 granted first, then m0; grant sequence 1,0,1,0 while both stay asserted.
REQ-027 Latch check: m0 write 0x1234_5678 with wstrb=0xF; m0_addr changes during BUSY -> s_addr stays at the latched value until s_ready.
REQ-028 Starvation: MAX_WAIT=2, arbitration forced to favour m0 repeatedly -> m1 is granted no later than its third contention.
REQ-029 Reset mid-BUSY: assert reset 1 cycle after s_valid rises -> s_valid=0 within the same cycle and no mX_ready pulse; a fresh request after release completes normally.
REQ-030 Spurious ready: s_ready pulse in IDLE -> m0_ready=m1_ready=0 and state unchanged.
